llr_user_scheduler: RTL and testbench

- Per-slot user sequencer for the slow-PHY-to-LLR converter.
- Holds a small table of per-user descriptors: IQ/noise rate and RE amount.
- On slot start it walks users 0..N-1. For each user it presents the descriptor to the converter, pulses the converter's FSM reset, counts converter output strobes until the user's RE amount is consumed, then advances.
- Flags bad descriptors, stalls (watchdog) and stray strobes.

---
 rtl/llr_sched_pkg.sv | 26 ++
 rtl/llr_user_cfg_ram.sv | 27 ++
 rtl/llr_user_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_llr_user_scheduler.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/llr_sched_pkg.sv
// Shared types for the per-slot LLR user scheduler: FSM states and the
// per-user descriptor layout stored in the configuration table.
package llr_sched_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StFrst,
      StRun,
      StNext,
      StDone
   } sched_state_e;

   // Each converter strobe carries one RE pair.
   localparam int unsigned RE_PER_STROBE = 2;

   typedef struct packed {
      logic [15:0] rate;
      logic [15:0] amounts;
   } user_desc_t;

   function automatic logic desc_is_bad(input user_desc_t d);
      return (d.rate == '0) || (d.amounts == '0);
   endfunction

endpackage

// File: rtl/llr_user_cfg_ram.sv
// Per-user descriptor table: one synchronous write port, one combinational
// read port. Contents are deliberately not reset.
module llr_user_cfg_ram
   import llr_sched_pkg::*;
#(
   parameter int unsigned MAX_USERS = 16,
   parameter int unsigned UAW       = $clog2(MAX_USERS)
) (
   input  logic                           clk_i,
   input  logic                           wr_en_i,
   input  logic [UAW-1:0]                 wr_addr_i,
   input  logic [$bits(user_desc_t)-1:0]  wr_data_i,
   input  logic [UAW-1:0]                 rd_addr_i,
   output logic [$bits(user_desc_t)-1:0]  rd_data_o
);

   logic [$bits(user_desc_t)-1:0] mem_q [MAX_USERS];

   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/llr_user_scheduler.sv
// Walks the users of a slot, presenting each descriptor to the LLR converter,
// pulsing its FSM reset and counting output strobes until the REs are consumed.
module llr_user_scheduler
   import llr_sched_pkg::*;
#(
   parameter int unsigned MAX_USERS      = 16,
   parameter int unsigned RST_CYCLES     = 2,
   parameter int unsigned TIMEOUT_CYCLES = 4096,
   localparam int unsigned UAW           = $clog2(MAX_USERS)
) (
   input  logic           i_core_clk,
   input  logic           i_rx_rstn,
   input  logic           i_cfg_wr_en,
   input  logic [UAW-1:0] i_cfg_wr_addr,
   input  logic [15:0]    i_cfg_wr_rate,
   input  logic [15:0]    i_cfg_wr_re_amounts,
   input  logic           i_slot_start,
   input  logic [UAW:0]   i_user_num,
   input  logic           i_data_strobe,
   output logic [15:0]    o_user_iq_noise_rate,
   output logic [15:0]    o_cur_user_re_amounts,
   output logic           o_fsm_rstn,
   output logic           o_user_active,
   output logic [UAW-1:0] o_user_idx,
   output logic           o_busy,
   output logic           o_slot_done,
   output logic           o_err_bad_cfg,
   output logic           o_err_timeout,
   output logic           o_err_stray,
   output logic           o_err_start_busy
);

   localparam int unsigned RCW = $clog2(RST_CYCLES + 1);
   localparam int unsigned WDW = $clog2(TIMEOUT_CYCLES + 1);

   sched_state_e   state_q, state_d;
   logic [UAW:0]   n_q, n_d;
   logic [UAW-1:0] idx_q, idx_d;
   logic [RCW-1:0] rst_cnt_q, rst_cnt_d;
   logic [16:0]    re_cnt_q, re_cnt_d;
   logic [WDW-1:0] wd_cnt_q, wd_cnt_d;
   logic [15:0]    rate_q, rate_d;
   logic [15:0]    amt_q, amt_d;
   logic           fsm_rstn_q, active_q, busy_q, done_q;
   logic           bad_q, bad_d, to_q, to_d, stray_q, start_busy_q;

   user_desc_t wr_desc, rd_desc;
   logic [$bits(user_desc_t)-1:0] rd_data;

   assign wr_desc = '{rate: i_cfg_wr_rate, amounts: i_cfg_wr_re_amounts};
   assign rd_desc = user_desc_t'(rd_data);

   llr_user_cfg_ram #(
      .MAX_USERS (MAX_USERS),
      .UAW       (UAW)
   ) u_cfg_ram (
      .clk_i     (i_core_clk),
      .wr_en_i   (i_cfg_wr_en),
      .wr_addr_i (i_cfg_wr_addr),
      .wr_data_i (wr_desc),
      .rd_addr_i (idx_q),
      .rd_data_o (rd_data)
   );

   always_comb begin
      state_d   = state_q;
      n_d       = n_q;
      idx_d     = idx_q;
      rst_cnt_d = rst_cnt_q;
      re_cnt_d  = re_cnt_q;
      wd_cnt_d  = wd_cnt_q;
      rate_d    = rate_q;
      amt_d     = amt_q;
      bad_d     = 1'b0;
      to_d      = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (i_slot_start) begin
               n_d     = (i_user_num > (UAW+1)'(MAX_USERS)) ? (UAW+1)'(MAX_USERS) : i_user_num;
               idx_d   = '0;
               state_d = (i_user_num == '0) ? StDone : StLoad;
            end
         end
         StLoad: begin
            rate_d = rd_desc.rate;
            amt_d  = rd_desc.amounts;
            if (desc_is_bad(rd_desc)) begin
               bad_d   = 1'b1;
               state_d = StNext;
            end else begin
               rst_cnt_d = '0;
               state_d   = StFrst;
            end
         end
         StFrst: begin
            if (rst_cnt_q == RCW'(RST_CYCLES - 1)) begin
               re_cnt_d = '0;
               wd_cnt_d = '0;
               state_d  = StRun;
            end else begin
               rst_cnt_d = rst_cnt_q + 1'b1;
            end
         end
         StRun: begin
            // A strobe takes priority over a watchdog expiry on the same cycle.
            if (i_data_strobe) begin
               re_cnt_d = re_cnt_q + 17'(RE_PER_STROBE);
               wd_cnt_d = '0;
               if (re_cnt_d >= {1'b0, amt_q}) begin
                  state_d = StNext;
               end
            end else if (wd_cnt_q == WDW'(TIMEOUT_CYCLES - 1)) begin
               to_d    = 1'b1;
               state_d = StNext;
            end else begin
               wd_cnt_d = wd_cnt_q + 1'b1;
            end
         end
         StNext: begin
            if ({1'b0, idx_q} == n_q - (UAW+1)'(1)) begin
               state_d = StDone;
            end else begin
               idx_d   = idx_q + 1'b1;
               state_d = StLoad;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge i_core_clk) begin
      if (!i_rx_rstn) begin
         state_q      <= StIdle;
         n_q          <= '0;
         idx_q        <= '0;
         rst_cnt_q    <= '0;
         re_cnt_q     <= '0;
         wd_cnt_q     <= '0;
         rate_q       <= '0;
         amt_q        <= '0;
         fsm_rstn_q   <= 1'b1;
         active_q     <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         bad_q        <= 1'b0;
         to_q         <= 1'b0;
         stray_q      <= 1'b0;
         start_busy_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         n_q          <= n_d;
         idx_q        <= idx_d;
         rst_cnt_q    <= rst_cnt_d;
         re_cnt_q     <= re_cnt_d;
         wd_cnt_q     <= wd_cnt_d;
         rate_q       <= rate_d;
         amt_q        <= amt_d;
         // Status outputs follow the state being entered so they line up with it.
         fsm_rstn_q   <= (state_d != StFrst);
         active_q     <= (state_d == StRun);
         busy_q       <= (state_d != StIdle) && (state_d != StDone);
         done_q       <= (state_d == StDone);
         bad_q        <= bad_d;
         to_q         <= to_d;
         stray_q      <= i_data_strobe && (state_q != StRun);
         start_busy_q <= i_slot_start && (state_q != StIdle);
      end
   end

   assign o_user_iq_noise_rate  = rate_q;
   assign o_cur_user_re_amounts = amt_q;
   assign o_fsm_rstn            = fsm_rstn_q;
   assign o_user_active         = active_q;
   assign o_user_idx            = idx_q;
   assign o_busy                = busy_q;
   assign o_slot_done           = done_q;
   assign o_err_bad_cfg         = bad_q;
   assign o_err_timeout         = to_q;
   assign o_err_stray           = stray_q;
   assign o_err_start_busy      = start_busy_q;

endmodule

// File: tb/tb_llr_user_scheduler.sv
// Bench for llr_user_scheduler: a phase-level slot model predicts every output
// each cycle while the bench plays the converter with directed and random strobes.
module tb_llr_user_scheduler;

   localparam int unsigned MU  = 16;
   localparam int unsigned RST = 2;
   localparam int unsigned TO  = 100;
   localparam int unsigned UAW = 4;

   localparam int PH_IDLE  = 0;
   localparam int PH_OTHER = 1;
   localparam int PH_RUN   = 2;

   logic           clk = 1'b0;
   logic           rstn;
   logic           wr_en;
   logic [UAW-1:0] wr_addr;
   logic [15:0]    wr_rate, wr_amt;
   logic           slot_start;
   logic [UAW:0]   user_num;
   logic           strobe;
   logic [15:0]    o_rate, o_amt;
   logic           o_fsm_rstn, o_act, o_busy, o_done, o_bad, o_to, o_stray, o_sb;
   logic [UAW-1:0] o_idx;

   always #5 clk = ~clk;

   llr_user_scheduler #(
      .MAX_USERS      (MU),
      .RST_CYCLES     (RST),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .i_core_clk            (clk),
      .i_rx_rstn             (rstn),
      .i_cfg_wr_en           (wr_en),
      .i_cfg_wr_addr         (wr_addr),
      .i_cfg_wr_rate         (wr_rate),
      .i_cfg_wr_re_amounts   (wr_amt),
      .i_slot_start          (slot_start),
      .i_user_num            (user_num),
      .i_data_strobe         (strobe),
      .o_user_iq_noise_rate  (o_rate),
      .o_cur_user_re_amounts (o_amt),
      .o_fsm_rstn            (o_fsm_rstn),
      .o_user_active         (o_act),
      .o_user_idx            (o_idx),
      .o_busy                (o_busy),
      .o_slot_done           (o_done),
      .o_err_bad_cfg         (o_bad),
      .o_err_timeout         (o_to),
      .o_err_stray           (o_stray),
      .o_err_start_busy      (o_sb)
   );

   int nchecks = 0;
   int nerr    = 0;
   int edge_n  = 0;

   // Model: descriptor table and expected outputs.
   logic [15:0]    m_rate [MU];
   logic [15:0]    m_amt  [MU];
   logic [15:0]    e_rate, e_amt;
   logic [UAW-1:0] e_idx;
   logic           e_rstn, e_act, e_busy, e_done, e_bad, e_to, e_stray, e_sb;
   int             m_phase = PH_IDLE;
   bit             chk_en  = 1'b0;

   int mon_rstn_low, mon_done, mon_done_edge, mon_bad, mon_to, mon_stray, mon_sb;
   int start_edge, last_strobe_edge, slot_strobes;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchecks++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("rate",        32'(o_rate),     32'(e_rate));
         chk("amounts",     32'(o_amt),      32'(e_amt));
         chk("fsm_rstn",    32'(o_fsm_rstn), 32'(e_rstn));
         chk("user_active", 32'(o_act),      32'(e_act));
         chk("user_idx",    32'(o_idx),      32'(e_idx));
         chk("busy",        32'(o_busy),     32'(e_busy));
         chk("slot_done",   32'(o_done),     32'(e_done));
         chk("err_bad_cfg", 32'(o_bad),      32'(e_bad));
         chk("err_timeout", 32'(o_to),       32'(e_to));
         chk("err_stray",   32'(o_stray),    32'(e_stray));
         chk("err_start",   32'(o_sb),       32'(e_sb));
         if (o_fsm_rstn === 1'b0) mon_rstn_low++;
         if (o_done === 1'b1) begin
            mon_done++;
            mon_done_edge = edge_n;
         end
         if (o_bad === 1'b1) mon_bad++;
         if (o_to === 1'b1) mon_to++;
         if (o_stray === 1'b1) mon_stray++;
         if (o_sb === 1'b1) mon_sb++;
      end
   end

   task automatic clr_mon();
      mon_rstn_low = 0; mon_done = 0; mon_done_edge = 0; mon_bad = 0;
      mon_to = 0; mon_stray = 0; mon_sb = 0; slot_strobes = 0;
   endtask

   // One clock: drive strobe/start for this edge, then update pulse expectations.
   task automatic cyc(input bit stb, input bit st);
      strobe = stb;
      slot_start = st;
      @(posedge clk);
      #1;
      edge_n++;
      strobe = 1'b0; slot_start = 1'b0; wr_en = 1'b0;
      e_done = 1'b0; e_bad = 1'b0; e_to = 1'b0;
      e_stray = stb && (m_phase != PH_RUN);
      e_sb    = st && (m_phase != PH_IDLE);
   endtask

   task automatic do_reset();
      rstn = 1'b0; strobe = 1'b0; slot_start = 1'b0; wr_en = 1'b0;
      @(posedge clk);
      #1;
      edge_n++;
      e_rate = '0; e_amt = '0; e_rstn = 1'b1; e_act = 1'b0; e_idx = '0; e_busy = 1'b0;
      e_done = 1'b0; e_bad = 1'b0; e_to = 1'b0; e_stray = 1'b0; e_sb = 1'b0;
      m_phase = PH_IDLE;
      rstn = 1'b1;
      chk_en = 1'b1;
   endtask

   task automatic set_wr(input int a, input int r, input int m);
      wr_en = 1'b1;
      wr_addr = UAW'(a);
      wr_rate = 16'(r);
      wr_amt = 16'(m);
      m_rate[a] = 16'(r);
      m_amt[a] = 16'(m);
   endtask

   task automatic wr(input int a, input int r, input int m);
      set_wr(a, r, m);
      cyc(1'b0, 1'b0);
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   // Plays one slot: converter strobes with optional random gaps, an optional
   // stall of user stall_u after 10 strobes, an optional busy start poke and
   // an optional reset after abort_at strobes of user 0.
   task automatic run_slot(input int unum, input int stall_u, input bit rnd,
                           input bit poke, input int abort_at);
      int n, s, got, gap;
      bit tmo;
      n = (unum > int'(MU)) ? int'(MU) : unum;
      user_num = (UAW+1)'(unum);
      cyc(1'b0, 1'b1);
      start_edge = edge_n;
      e_idx = '0;
      if (n == 0) begin
         e_done = 1'b1;
         m_phase = PH_OTHER;
         cyc(1'b0, 1'b0);
         m_phase = PH_IDLE;
         return;
      end
      e_busy = 1'b1;
      m_phase = PH_OTHER;
      for (int u = 0; u < n; u++) begin
         cyc(1'b0, 1'b0);
         e_rate = m_rate[u];
         e_amt = m_amt[u];
         if (e_rate == 16'd0 || e_amt == 16'd0) begin
            e_bad = 1'b1;
         end else begin
            e_rstn = 1'b0;
            for (int r = 1; r < int'(RST); r++) cyc(1'b0, 1'b0);
            cyc(1'b0, 1'b0);
            e_rstn = 1'b1;
            e_act = 1'b1;
            m_phase = PH_RUN;
            s = (int'(e_amt) + 1) / 2;
            got = 0;
            tmo = 1'b0;
            while (got < s && !tmo) begin
               if (u == stall_u && got == 10) gap = int'(TO);
               else if (rnd) gap = ($urandom_range(0, 31) == 0) ? int'(TO) - 1
                                                               : int'($urandom_range(0, 2));
               else gap = 0;
               for (int g = 0; g < gap && !tmo; g++) begin
                  if (rnd && $urandom_range(0, 15) == 0)
                     set_wr(int'($urandom_range(0, MU - 1)), int'($urandom_range(1, 15)),
                            int'($urandom_range(1, 40)));
                  cyc(1'b0, 1'b0);
                  if (g + 1 == int'(TO)) begin
                     e_to = 1'b1; e_act = 1'b0; m_phase = PH_OTHER; tmo = 1'b1;
                  end
               end
               if (!tmo) begin
                  if (u == 0 && got == abort_at) begin
                     do_reset();
                     return;
                  end
                  cyc(1'b1, poke && u == 0 && got == 0);
                  got++;
                  slot_strobes++;
                  last_strobe_edge = edge_n;
                  if (got == s) begin
                     e_act = 1'b0;
                     m_phase = PH_OTHER;
                  end
               end
            end
         end
         cyc(1'b0, 1'b0);
         if (u == n - 1) begin
            e_done = 1'b1;
            e_busy = 1'b0;
         end else begin
            e_idx = UAW'(u + 1);
         end
      end
      cyc(1'b0, 1'b0);
      m_phase = PH_IDLE;
   endtask

   initial begin
      rstn = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_rate = '0; wr_amt = '0;
      slot_start = 1'b0; user_num = '0; strobe = 1'b0;
      repeat (2) @(posedge clk);
      do_reset();

      // Single user 6/1797, converter strobing every cycle.
      wr(0, 6, 1797);
      clr_mon();
      run_slot(1, -1, 1'b0, 1'b0, -1);
      settle();
      chk("t1_strobes", 32'(slot_strobes), 32'd899);
      chk("t1_rstn_low", 32'(mon_rstn_low), 32'd2);
      chk("t1_done_cnt", 32'(mon_done), 32'd1);
      chk("t1_start_to_done", 32'(mon_done_edge - start_edge), 32'd903);
      chk("t1_strobe_to_done", 32'(mon_done_edge - last_strobe_edge), 32'd1);

      // Three users.
      wr(1, 4, 100);
      wr(2, 2, 1);
      clr_mon();
      run_slot(3, -1, 1'b0, 1'b0, -1);
      settle();
      chk("t2_strobes", 32'(slot_strobes), 32'd950);
      chk("t2_rstn_low", 32'(mon_rstn_low), 32'd6);
      chk("t2_done_cnt", 32'(mon_done), 32'd1);

      // Empty slot.
      clr_mon();
      run_slot(0, -1, 1'b0, 1'b0, -1);
      settle();
      chk("t3_rstn_low", 32'(mon_rstn_low), 32'd0);
      chk("t3_done_cnt", 32'(mon_done), 32'd1);

      // Bad descriptor in the middle.
      wr(1, 4, 0);
      clr_mon();
      run_slot(3, -1, 1'b0, 1'b0, -1);
      settle();
      chk("t4_bad_cnt", 32'(mon_bad), 32'd1);
      chk("t4_rstn_low", 32'(mon_rstn_low), 32'd4);
      chk("t4_strobes", 32'(slot_strobes), 32'd900);

      // Stray strobe while idle.
      clr_mon();
      cyc(1'b1, 1'b0);
      settle();
      chk("t5_stray_cnt", 32'(mon_stray), 32'd1);

      // Converter stalls after 10 strobes on user 0.
      wr(0, 3, 100);
      wr(1, 5, 7);
      clr_mon();
      run_slot(2, 0, 1'b0, 1'b0, -1);
      settle();
      chk("t6_timeout_cnt", 32'(mon_to), 32'd1);
      chk("t6_strobes", 32'(slot_strobes), 32'd14);
      chk("t6_done_cnt", 32'(mon_done), 32'd1);

      // Start pulse while a user runs.
      wr(0, 6, 20);
      clr_mon();
      run_slot(1, -1, 1'b0, 1'b1, -1);
      settle();
      chk("t7_start_busy_cnt", 32'(mon_sb), 32'd1);
      chk("t7_done_cnt", 32'(mon_done), 32'd1);

      // user_num above the table depth is clamped.
      for (int i = 0; i < int'(MU); i++) wr(i, i + 1, i + 1);
      clr_mon();
      run_slot(20, -1, 1'b0, 1'b0, -1);
      settle();
      chk("t8_rstn_low", 32'(mon_rstn_low), 32'd32);
      chk("t8_done_cnt", 32'(mon_done), 32'd1);

      // Reset mid-run, then a clean slot.
      wr(0, 6, 1797);
      clr_mon();
      run_slot(2, -1, 1'b0, 1'b0, 5);
      settle();
      chk("t9_abort_done_cnt", 32'(mon_done), 32'd0);
      clr_mon();
      run_slot(1, -1, 1'b0, 1'b0, -1);
      settle();
      chk("t9_after_done_cnt", 32'(mon_done), 32'd1);

      // Random slots with random tables, gaps, and live table writes.
      for (int t = 0; t < 20; t++) begin
         for (int i = 0; i < int'(MU); i++)
            wr(i, ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 65535)),
               ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 40)));
         run_slot(int'($urandom_range(0, 8)), -1, 1'b1, 1'b0, -1);
      end
      settle();

      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
      $finish;
   end

endmodule
